// File: rtl/serial_parallel_sync_pkg.sv
// serial_parallel_sync_pkg
//   Shared definitions for the serial_parallel_sync receiver:
//   - sp_state_e   : alignment FSM state encoding
//   - ComDefault   : default comma symbol (8-bit K28.5, 8'hBC)
//   - ComK28p5     : alias of the default comma
//   - cnt_width()  : bit width needed for a counter that must hold 0..max_val

package serial_parallel_sync_pkg;

    typedef enum logic [1:0] {
        StSearch = 2'd0,
        StAlign  = 2'd1,
        StLock   = 2'd2
    } sp_state_e;

    localparam logic [7:0] ComDefault = 8'hBC;
    localparam logic [7:0] ComK28p5   = ComDefault;

    // A zero range still needs one bit so the counter can be declared at all.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sp_word_framer.sv
// sp_word_framer
//   Serial-in shift register plus free-running bit counter that marks word
//   boundaries for an MSB-first stream.
//   Ports:
//     clk      : bit clock, rising edge
//     rst_n    : synchronous active-low reset
//     bit_in   : serial data bit sampled every edge
//     restart  : forces the bit counter to 0 at this edge (this edge ends a word)
//     word     : candidate word {previous WIDTH-1 bits, bit_in}
//     boundary : high when the current edge samples the last bit of a word

module sp_word_framer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             restart,
    output logic [WIDTH-1:0] word,
    output logic             boundary
);

    localparam int unsigned    CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    // Only the newest WIDTH-1 bits are ever needed: the oldest bit of a full
    // WIDTH-bit register would be shifted out before it is looked at.
    logic [WIDTH-2:0] sr_q;
    logic [CntW-1:0]  bit_cnt_q;

    assign word     = {sr_q, bit_in};
    assign boundary = (bit_cnt_q == LastBit);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
        end else begin
            sr_q <= word[WIDTH-2:0];
            if (restart || boundary) begin
                bit_cnt_q <= '0;
            end else begin
                bit_cnt_q <= bit_cnt_q + CntW'(1);
            end
        end
    end

endmodule

// File: rtl/serial_parallel_sync.sv
// serial_parallel_sync
//   Deserialises an MSB-first bit stream into WIDTH-bit words, aligns on a
//   comma symbol and declares lock after SYNC_COUNT consecutive aligned commas.
//   Lock is dropped after LOSS_WORDS consecutive non-comma words (0 = never).
//   Ports:
//     CLK       : bit clock, rising edge
//     RESET     : synchronous active-low reset
//     DATA_IN   : serial data, MSB of each word first
//     DATA_OUT  : last non-comma word received while locked
//     VALID_OUT : one-cycle pulse when DATA_OUT is updated
//     ACTIVE    : high while locked

module serial_parallel_sync
    import serial_parallel_sync_pkg::*;
#(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] COM        = WIDTH'(ComDefault),
    parameter int unsigned      SYNC_COUNT = 4,
    parameter int unsigned      LOSS_WORDS = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             DATA_IN,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic             VALID_OUT,
    output logic             ACTIVE
);

    localparam int unsigned ComCntW = cnt_width(SYNC_COUNT);
    localparam int unsigned GapCntW = cnt_width(LOSS_WORDS);

    localparam logic [ComCntW-1:0] SyncTarget = ComCntW'(SYNC_COUNT);
    localparam logic [GapCntW-1:0] LossTarget = GapCntW'(LOSS_WORDS);
    localparam logic [GapCntW-1:0] GapMax     = {GapCntW{1'b1}};

    logic [WIDTH-1:0]   word;
    logic               boundary;
    logic               is_com;
    logic               restart;

    sp_state_e          state_q;
    logic [ComCntW-1:0] com_cnt_q;
    logic [ComCntW-1:0] com_cnt_inc;
    logic [GapCntW-1:0] gap_cnt_q;
    logic [GapCntW-1:0] gap_cnt_inc;
    logic [WIDTH-1:0]   data_q;
    logic               valid_q;
    logic               active_q;

    sp_word_framer #(
        .WIDTH (WIDTH)
    ) u_framer (
        .clk      (CLK),
        .rst_n    (RESET),
        .bit_in   (DATA_IN),
        .restart  (restart),
        .word     (word),
        .boundary (boundary)
    );

    assign is_com = (word == COM);

    // Only SEARCH may move the word grid; once aligned, a comma that straddles
    // a boundary is deliberately ignored.
    assign restart = (state_q == StSearch) && is_com;

    assign com_cnt_inc = com_cnt_q + ComCntW'(1);
    assign gap_cnt_inc = (gap_cnt_q == GapMax) ? gap_cnt_q : gap_cnt_q + GapCntW'(1);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q   <= StSearch;
            com_cnt_q <= '0;
            gap_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                StSearch: begin
                    if (is_com) begin
                        com_cnt_q <= ComCntW'(1);
                        if (SYNC_COUNT == 1) begin
                            state_q   <= StLock;
                            active_q  <= 1'b1;
                            gap_cnt_q <= '0;
                        end else begin
                            state_q <= StAlign;
                        end
                    end
                end

                StAlign: begin
                    if (boundary) begin
                        if (is_com) begin
                            com_cnt_q <= com_cnt_inc;
                            if (com_cnt_inc == SyncTarget) begin
                                state_q   <= StLock;
                                active_q  <= 1'b1;
                                gap_cnt_q <= '0;
                            end
                        end else begin
                            state_q   <= StSearch;
                            com_cnt_q <= '0;
                        end
                    end
                end

                StLock: begin
                    if (boundary) begin
                        if (is_com) begin
                            gap_cnt_q <= '0;
                        end else begin
                            data_q    <= word;
                            valid_q   <= 1'b1;
                            gap_cnt_q <= gap_cnt_inc;
                            // The word that exhausts the gap budget is still
                            // delivered; lock is dropped at the same edge.
                            if ((LOSS_WORDS != 0) && (gap_cnt_inc == LossTarget)) begin
                                state_q   <= StSearch;
                                active_q  <= 1'b0;
                                com_cnt_q <= '0;
                            end
                        end
                    end
                end

                default: begin
                    state_q   <= StSearch;
                    com_cnt_q <= '0;
                    active_q  <= 1'b0;
                end
            endcase
        end
    end

    assign DATA_OUT  = data_q;
    assign VALID_OUT = valid_q;
    assign ACTIVE    = active_q;

endmodule

// File: tb/tb_serial_parallel_sync.sv
// tb_serial_parallel_sync
//   Drives an 8-bit (COM=BC) and a 10-bit (COM=17C) instance with directed and
//   random bit streams. A behavioural model (word history as an integer, word
//   phase as a modulo count) predicts every output each cycle; directed checks
//   additionally pin the documented scenarios to constant expectations.

module tb_serial_parallel_sync;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] din;

    logic [7:0] dout8;
    logic       v8;
    logic       a8;
    logic [9:0] dout10;
    logic       v10;
    logic       a10;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_parallel_sync #(
        .WIDTH      (8),
        .COM        (8'hBC),
        .SYNC_COUNT (4),
        .LOSS_WORDS (16)
    ) dut8 (
        .CLK       (clk),
        .RESET     (rst_n),
        .DATA_IN   (din[0]),
        .DATA_OUT  (dout8),
        .VALID_OUT (v8),
        .ACTIVE    (a8)
    );

    serial_parallel_sync #(
        .WIDTH      (10),
        .COM        (10'h17C),
        .SYNC_COUNT (4),
        .LOSS_WORDS (16)
    ) dut10 (
        .CLK       (clk),
        .RESET     (rst_n),
        .DATA_IN   (din[1]),
        .DATA_OUT  (dout10),
        .VALID_OUT (v10),
        .ACTIVE    (a10)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int unsigned m_w[2]   = '{8, 10};
    int unsigned m_com[2] = '{32'hBC, 32'h17C};
    int          m_mode[2];   // 0 hunting, 1 counting commas, 2 locked
    int          m_phase[2];  // bits received in the current word
    int          m_coms[2];
    int          m_gap[2];
    int unsigned m_hist[2];
    int unsigned m_dout[2];
    bit          m_vout[2];
    bit          m_act[2];

    function automatic void model_step(input int k, input bit r, input bit b);
        int unsigned w;
        int unsigned word;
        bit          at_end;
        if (!r) begin
            m_mode[k]  = 0;
            m_phase[k] = 0;
            m_coms[k]  = 0;
            m_gap[k]   = 0;
            m_hist[k]  = 0;
            m_dout[k]  = 0;
            m_vout[k]  = 0;
            m_act[k]   = 0;
            return;
        end
        w          = m_w[k];
        word       = (m_hist[k] * 2 + b) % (32'd1 << w);
        m_hist[k]  = word;
        at_end     = (m_phase[k] == int'(w) - 1);
        m_phase[k] = (m_phase[k] + 1) % int'(w);
        m_vout[k]  = 0;
        case (m_mode[k])
            0: begin
                if (word == m_com[k]) begin
                    m_phase[k] = 0;
                    m_coms[k]  = 1;
                    m_mode[k]  = 1;
                end
            end
            1: begin
                if (at_end) begin
                    if (word == m_com[k]) begin
                        m_coms[k]++;
                        if (m_coms[k] == 4) begin
                            m_mode[k] = 2;
                            m_act[k]  = 1;
                            m_gap[k]  = 0;
                        end
                    end else begin
                        m_mode[k] = 0;
                        m_coms[k] = 0;
                    end
                end
            end
            default: begin
                if (at_end) begin
                    if (word == m_com[k]) begin
                        m_gap[k] = 0;
                    end else begin
                        m_dout[k] = word;
                        m_vout[k] = 1;
                        m_gap[k]++;
                        if (m_gap[k] == 16) begin
                            m_mode[k] = 0;
                            m_act[k]  = 0;
                            m_coms[k] = 0;
                        end
                    end
                end
            end
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    int          cyc = 0;
    int          vcnt[2];
    int unsigned vdata[2];
    int          vcyc[2];
    int          vgap[2];

    task automatic tick(input bit r, input bit b0, input bit b1);
        rst_n = r;
        din   = {b1, b0};
        @(posedge clk);
        model_step(0, r, b0);
        model_step(1, r, b1);
        #1;
        cyc++;
        check_val("dout8",  32'(dout8),  m_dout[0]);
        check_val("valid8", 32'(v8),     32'(m_vout[0]));
        check_val("act8",   32'(a8),     32'(m_act[0]));
        check_val("dout10", 32'(dout10), m_dout[1]);
        check_val("valid10", 32'(v10),   32'(m_vout[1]));
        check_val("act10",  32'(a10),    32'(m_act[1]));
        if (v8) begin
            vcnt[0]++;
            vgap[0]  = cyc - vcyc[0];
            vcyc[0]  = cyc;
            vdata[0] = 32'(dout8);
        end
        if (v10) begin
            vcnt[1]++;
            vgap[1]  = cyc - vcyc[1];
            vcyc[1]  = cyc;
            vdata[1] = 32'(dout10);
        end
    endtask

    task automatic send8(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) tick(1'b1, w[i], 1'b0);
    endtask

    task automatic send10(input logic [9:0] w);
        for (int i = 9; i >= 0; i--) tick(1'b1, 1'b0, w[i]);
    endtask

    logic [7:0]  pre;
    logic [7:0]  part8;
    logic [9:0]  part10;
    logic [31:0] cur[2];
    int          idx[2];
    int          dens[2];

    initial begin
        rst_n = 1'b0;
        din   = 2'b00;

        // Reset with random data, then 3 random bits: nothing may happen.
        tick(1'b0, 1'($urandom), 1'($urandom));
        tick(1'b0, 1'($urandom), 1'($urandom));
        check_val("rst_dout8", 32'(dout8), 32'h0);
        check_val("rst_valid8", 32'(v8), 32'h0);
        check_val("rst_act8", 32'(a8), 32'h0);
        check_val("rst_act10", 32'(a10), 32'h0);
        do pre = 8'($urandom); while (pre == 8'hBC);
        vcnt[0] = 0;
        for (int i = 7; i >= 5; i--) tick(1'b1, pre[i], 1'b0);
        check_val("idle_vcnt", 32'(vcnt[0]), 32'd0);
        check_val("idle_act", 32'(a8), 32'd0);

        // Lock: 5 more random bits, 4x BC, then 3C and A5.
        for (int i = 4; i >= 0; i--) tick(1'b1, pre[i], 1'b0);
        for (int n = 0; n < 3; n++) send8(8'hBC);
        part8 = 8'hBC;
        for (int i = 7; i >= 1; i--) tick(1'b1, part8[i], 1'b0);
        check_val("pre_lock_act", 32'(a8), 32'd0);
        tick(1'b1, part8[0], 1'b0);
        check_val("lock_act", 32'(a8), 32'd1);
        check_val("lock_novalid", 32'(vcnt[0]), 32'd0);
        send8(8'h3C);
        check_val("first_valid", 32'(v8), 32'd1);
        check_val("first_data", 32'(dout8), 32'h3C);
        send8(8'hA5);
        check_val("two_pulses", 32'(vcnt[0]), 32'd2);
        check_val("second_data", vdata[0], 32'hA5);
        check_val("pulse_spacing", 32'(vgap[0]), 32'd8);

        // COM filtering while locked.
        vcnt[0] = 0;
        send8(8'h11);
        check_val("filt_11", 32'(dout8), 32'h11);
        send8(8'hBC);
        check_val("filt_hold", 32'(dout8), 32'h11);
        check_val("filt_com_novalid", 32'(v8), 32'd0);
        send8(8'h22);
        check_val("filt_count", 32'(vcnt[0]), 32'd2);
        check_val("filt_22", 32'(dout8), 32'h22);

        // Loss of lock after 16 non-COM words (BC first to clear the gap).
        send8(8'hBC);
        vcnt[0] = 0;
        for (int i = 1; i <= 16; i++) begin
            send8(8'(i));
            if (i == 15) check_val("loss_still_active", 32'(a8), 32'd1);
        end
        check_val("loss_act", 32'(a8), 32'd0);
        check_val("loss_last_valid", 32'(v8), 32'd1);
        check_val("loss_data", 32'(dout8), 32'h10);
        check_val("loss_count", 32'(vcnt[0]), 32'd16);
        send8(8'h77);
        check_val("loss_hold", 32'(dout8), 32'h10);
        check_val("loss_silent", 32'(vcnt[0]), 32'd16);

        // Short sync: 3x BC then 55 stays unlocked; 4x BC then locks.
        vcnt[0] = 0;
        for (int n = 0; n < 3; n++) send8(8'hBC);
        send8(8'h55);
        check_val("short_act", 32'(a8), 32'd0);
        check_val("short_novalid", 32'(vcnt[0]), 32'd0);
        for (int n = 0; n < 4; n++) send8(8'hBC);
        check_val("resync_act", 32'(a8), 32'd1);

        // Reset mid-lock during bit 3 of a data word, then relock.
        send8(8'h5A);
        check_val("pre_rst_data", 32'(dout8), 32'h5A);
        part8 = 8'h77;
        for (int i = 7; i >= 5; i--) tick(1'b1, part8[i], 1'b0);
        tick(1'b0, part8[4], 1'b0);
        check_val("midrst_dout8", 32'(dout8), 32'h0);
        check_val("midrst_valid8", 32'(v8), 32'h0);
        check_val("midrst_act8", 32'(a8), 32'h0);
        for (int n = 0; n < 4; n++) send8(8'hBC);
        check_val("relock_act8", 32'(a8), 32'd1);
        send8(8'hC3);
        check_val("relock_data8", 32'(dout8), 32'hC3);

        // Same scenario on the 10-bit instance.
        for (int n = 0; n < 4; n++) send10(10'h17C);
        check_val("lock_act10", 32'(a10), 32'd1);
        send10(10'h2A5);
        check_val("data10", 32'(dout10), 32'h2A5);
        check_val("valid10_pulse", 32'(v10), 32'd1);
        part10 = 10'h0F3;
        for (int i = 9; i >= 7; i--) tick(1'b1, 1'b0, part10[i]);
        tick(1'b0, 1'b0, part10[6]);
        check_val("midrst_dout10", 32'(dout10), 32'h0);
        check_val("midrst_valid10", 32'(v10), 32'h0);
        check_val("midrst_act10", 32'(a10), 32'h0);
        for (int n = 0; n < 4; n++) send10(10'h17C);
        check_val("relock_act10", 32'(a10), 32'd1);
        send10(10'h1F0);
        check_val("relock_data10", 32'(dout10), 32'h1F0);

        // Random streams: bursts of comma-rich and comma-poor words, occasional
        // dropped bits to force misalignment, and rare resets.
        idx[0]  = -1;
        idx[1]  = -1;
        dens[0] = 9;
        dens[1] = 9;
        for (int c = 0; c < 6000; c++) begin
            bit r;
            bit b[2];
            r = ($urandom_range(0, 499) != 0);
            if ((c % 320) == 0) begin
                dens[0] = $urandom_range(0, 2) * 4 + 1;
                dens[1] = $urandom_range(0, 2) * 4 + 1;
            end
            for (int k = 0; k < 2; k++) begin
                if (idx[k] < 0) begin
                    if ($urandom_range(0, 9) < dens[k]) cur[k] = m_com[k];
                    else cur[k] = $urandom;
                    idx[k] = int'(m_w[k]) - 1;
                    if ($urandom_range(0, 39) == 0) idx[k] = idx[k] - 1;
                end
                b[k] = cur[k][idx[k]];
                idx[k]--;
            end
            tick(r, b[0], b[1]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_parallel_sync.md
Name: serial_parallel_sync

Overview:
- Parametrised successor of the fixed 8-bit serial_parallel converter: deserialises a 1-bit MSB-first stream into WIDTH-bit words.
- Aligns itself on a comma symbol (COM) and declares lock after SYNC_COUNT consecutive aligned COMs.
- Drops lock when COM disappears for too long.
- Sits on the receive side of the physical layer, between the serial line and the byte-level logic.

Parameters:
WIDTH, 8, word width in bits (>=4)
COM, 8'hBC, comma symbol, WIDTH bits
SYNC_COUNT, 4, consecutive aligned COM words required to lock (>=1)
LOSS_WORDS, 16, consecutive non-COM words while locked before lock is dropped; 0 disables loss detection

Ports:
CLK  input  1  bit clock, rising edge
RESET  input  1  synchronous, active-low reset
DATA_IN  input  1  serial data, sampled every rising CLK edge, MSB of each word first
DATA_OUT  output  WIDTH  last non-COM word received while locked
VALID_OUT  output  1  one-cycle pulse when DATA_OUT is updated
ACTIVE  output  1  high while locked

Behaviour:
- Reset: RESET is synchronous and active-low. RESET==0 at a rising CLK edge clears:
  - the shift register and bit counter;
  - the COM counter and gap counter;
  - DATA_OUT=0, VALID_OUT=0, ACTIVE=0;
  - state=SEARCH.
- Reset applies in every state, including mid-word or mid-lock.
- Shift register: each edge, sr <= {sr[WIDTH-2:0], DATA_IN}. The candidate word is w = {sr[WIDTH-2:0], DATA_IN}.
- Bit counter:
  - 0..WIDTH-1, wraps.
  - A word boundary occurs at an edge where the counter is WIDTH-1.
- State SEARCH (ACTIVE=0, VALID_OUT=0):
  - Every edge, compare w to COM.
  - On match: bit counter <= 0 (this edge ends a word), COM count <= 1.
  - Then go to ALIGN, or go directly to LOCK if SYNC_COUNT==1.
- State ALIGN:
  - Checked only at word boundaries.
  - w==COM: COM count increments. On reaching SYNC_COUNT, go to LOCK, set ACTIVE<=1, gap counter <= 0.
  - w!=COM: back to SEARCH, COM count <= 0.
  - No bit slip is applied while in ALIGN.
- State LOCK (ACTIVE=1). At each word boundary:
  - w!=COM: DATA_OUT<=w, VALID_OUT<=1 for one cycle, gap counter increments.
  - w==COM: DATA_OUT holds, VALID_OUT=0, gap counter <= 0.
  - If LOSS_WORDS!=0 and the gap counter reaches LOSS_WORDS on this boundary:
    - the word is still output;
    - at the same edge, state <= SEARCH and ACTIVE<=0;
    - DATA_OUT holds its last value.
- Latency: DATA_OUT and VALID_OUT update at the same edge that samples a word's last bit, so they are visible in the following cycle.
- VALID_OUT is never high in two consecutive cycles unless WIDTH==1; WIDTH>=4 makes this impossible.
- The first word able to produce VALID_OUT is the one after the locking COM.
- A COM pattern straddling a word boundary while in ALIGN or LOCK is ignored: no realignment without leaving lock.
- Width rules:
  - The gap counter is $clog2(LOSS_WORDS+1) bits and saturates.
  - The COM counter is $clog2(SYNC_COUNT+1) bits.

Decomposition:
- Shared package holds:
  - state encoding (SEARCH=2'd0, ALIGN=2'd1, LOCK=2'd2);
  - the default COM symbol constant (8'hBC) and its K28.5 alias;
  - a helper function for counter widths.
- Natural sub-module: sp_word_framer, containing the shift register, the bit counter, the boundary flag and the counter-restart input.
- The top level holds the FSM, counters and output registers.

Test Plan:
- Reset: RESET=0 for 2 edges with random DATA_IN -> DATA_OUT=0, VALID_OUT=0, ACTIVE=0. Release, then 3 random bits -> no output activity.
- Lock: 5 random bits, then 4x 8'hBC, then 8'h3C, 8'hA5 -> ACTIVE rises the cycle after the 4th BC's last bit. VALID_OUT pulses exactly twice, with DATA_OUT=3C then A5, 8 cycles apart.
- Short sync: 3x BC, then 8'h55 -> remains SEARCH. ACTIVE=0, no VALID_OUT. A following 4x BC then locks.
- COM filtering: while locked, send 11, BC, 22 -> VALID_OUT pulses for 11 and 22 only; DATA_OUT holds 11 through the BC word.
- Loss of lock (LOSS_WORDS=16): while locked, send 16 non-COM words 01..10 -> 16 VALID_OUT pulses. ACTIVE falls at the edge of word 10, and DATA_OUT stays 10.
- Reset mid-lock: assert RESET during bit 3 of a data word -> all outputs 0 next cycle. After release, 4x BC relocks. Repeat with WIDTH=10, COM=10'h17C.
